// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the
// memory stage; data accesses win, and a flushed fetch discards its result.
module mem_port_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead_M,
    input  logic             memWrite_M,
    input  logic [width-1:0] addr_M,
    input  logic [width-1:0] writeData_M,
    input  logic             hold_M,
    output logic [width-1:0] readData_M,
    output logic             stall_M,
    input  logic             fetchReq_F,
    input  logic [width-1:0] pc_F,
    input  logic             flush_F,
    input  logic             hold_F,
    output logic [width-1:0] instr_F,
    output logic             stall_F,
    output logic             memReq,
    output logic             memWe,
    output logic [width-1:0] memAddr,
    output logic [width-1:0] memWData,
    input  logic [width-1:0] memRData,
    input  logic             memAck
);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

    state_t stateReg, stateNext;
    logic   doneMReg, doneFReg, dropReg;
    logic   reqM, startData, startInstr;

    assign reqM       = memRead_M | memWrite_M;
    assign startData  = reqM & ~doneMReg;
    assign startInstr = ~startData & fetchReq_F & ~doneFReg & ~flush_F;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (startData)
                    stateNext = DATA;
                else if (startInstr)
                    stateNext = INSTR;
            end
            DATA:    if (memAck) stateNext = IDLE;
            INSTR:   if (memAck) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= IDLE;
            doneMReg   <= 1'b0;
            doneFReg   <= 1'b0;
            dropReg    <= 1'b0;
            readData_M <= '0;
            instr_F    <= '0;
            memAddr    <= '0;
            memWData   <= '0;
            memWe      <= 1'b0;
        end else begin
            stateReg <= stateNext;

            // The done flags remember a finished access until the instruction
            // leaves its stage, so a held instruction never re-issues.
            if (stateReg == DATA && memAck)
                doneMReg <= 1'b1;
            else if (doneMReg && !hold_M)
                doneMReg <= 1'b0;

            if (stateReg == INSTR && memAck && !dropReg && !flush_F)
                doneFReg <= 1'b1;
            else if ((doneFReg && !hold_F) || flush_F)
                doneFReg <= 1'b0;

            case (stateReg)
                IDLE: begin
                    if (startData) begin
                        memAddr  <= addr_M;
                        memWData <= writeData_M;
                        memWe    <= memWrite_M;
                    end else if (startInstr) begin
                        memAddr <= pc_F;
                        memWe   <= 1'b0;
                    end
                end
                DATA: begin
                    if (memAck && !memWe)
                        readData_M <= memRData;
                end
                INSTR: begin
                    if (memAck) begin
                        if (!dropReg && !flush_F)
                            instr_F <= memRData;
                        dropReg <= 1'b0;
                    end else if (flush_F) begin
                        dropReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memReq  = (stateReg != IDLE);
    assign stall_M = reqM & ~doneMReg;
    assign stall_F = fetchReq_F & ~doneFReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory, driving
// memAck/memRData cycle by cycle, and checks outputs 1ns after each clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead_M, memWrite_M, hold_M;
    logic [31:0] addr_M, writeData_M, readData_M;
    logic        stall_M;
    logic        fetchReq_F, flush_F, hold_F, stall_F;
    logic [31:0] pc_F, instr_F;
    logic        memReq, memWe, memAck;
    logic [31:0] memAddr, memWData, memRData;

    int checks = 0;
    int errors = 0;
    int reqCycles;

    mem_port_arbiter #(.width(32)) dut (
        .clk(clk), .reset(reset),
        .memRead_M(memRead_M), .memWrite_M(memWrite_M), .addr_M(addr_M),
        .writeData_M(writeData_M), .hold_M(hold_M), .readData_M(readData_M),
        .stall_M(stall_M), .fetchReq_F(fetchReq_F), .pc_F(pc_F),
        .flush_F(flush_F), .hold_F(hold_F), .instr_F(instr_F), .stall_F(stall_F),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memAck(memAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        memRead_M = 0; memWrite_M = 0; hold_M = 0; addr_M = 0; writeData_M = 0;
        fetchReq_F = 0; flush_F = 0; hold_F = 0; pc_F = 0;
        memAck = 0; memRData = 0;
        step(); step();
        chk("rst memReq", 32'(memReq), 32'd0);
        chk("rst stall_M", 32'(stall_M), 32'd0);
        chk("rst stall_F", 32'(stall_F), 32'd0);
        chk("rst readData_M", readData_M, 32'h0);
        chk("rst instr_F", instr_F, 32'h0);
        chk("rst memAddr", memAddr, 32'h0);
        chk("rst memWData", memWData, 32'h0);
        chk("rst memWe", 32'(memWe), 32'd0);

        // Zero-wait load
        reset = 0; memRead_M = 1; addr_M = 32'h100;
        #1;
        chk("ld0 stall_M c0", 32'(stall_M), 32'd1);
        chk("ld0 memReq c0", 32'(memReq), 32'd0);
        step();
        chk("ld0 memReq c1", 32'(memReq), 32'd1);
        chk("ld0 memAddr", memAddr, 32'h100);
        chk("ld0 memWe", 32'(memWe), 32'd0);
        chk("ld0 stall_M c1", 32'(stall_M), 32'd1);
        memAck = 1; memRData = 32'hDEADBEEF;
        step();
        memAck = 0;
        chk("ld0 memReq c2", 32'(memReq), 32'd0);
        chk("ld0 stall_M c2", 32'(stall_M), 32'd0);
        chk("ld0 readData_M", readData_M, 32'hDEADBEEF);
        memRead_M = 0;
        step();

        // Load followed by 4 cycles of hold_M
        memRead_M = 1; addr_M = 32'h104; hold_M = 1;
        step();
        chk("hld memAddr", memAddr, 32'h104);
        memAck = 1; memRData = 32'h11223344;
        step();
        memAck = 0;
        chk("hld readData_M", readData_M, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hld%0d memReq", i), 32'(memReq), 32'd0);
            chk($sformatf("hld%0d stall_M", i), 32'(stall_M), 32'd0);
            chk($sformatf("hld%0d readData_M", i), readData_M, 32'h11223344);
        end
        hold_M = 0; memRead_M = 0;
        step();

        // Store with 3 wait cycles; request inputs change mid-access
        memWrite_M = 1; addr_M = 32'h40; writeData_M = 32'h55AA;
        step();
        reqCycles = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("st c%0d memReq", i), 32'(memReq), 32'd1);
            chk($sformatf("st c%0d memWe", i), 32'(memWe), 32'd1);
            chk($sformatf("st c%0d memAddr", i), memAddr, 32'h40);
            chk($sformatf("st c%0d memWData", i), memWData, 32'h55AA);
            chk($sformatf("st c%0d stall_M", i), 32'(stall_M), 32'd1);
            reqCycles += 32'(memReq);
            addr_M = 32'h44; writeData_M = 32'h1234;
            if (i == 2) begin
                memAck = 1; memRData = 32'hBAD0BAD0;
            end
            step();
        end
        memAck = 0;
        chk("st stall_M done", 32'(stall_M), 32'd0);
        chk("st readData_M kept", readData_M, 32'h11223344);
        reqCycles += 32'(memReq);
        memWrite_M = 0;
        step();
        reqCycles += 32'(memReq);
        chk("st memReq cycles", 32'(reqCycles), 32'd3);

        // Load and fetch pending together: data first, then fetch
        memRead_M = 1; addr_M = 32'h200; fetchReq_F = 1; pc_F = 32'h8;
        #1;
        chk("sim stall_F c0", 32'(stall_F), 32'd1);
        step();
        chk("sim memAddr data", memAddr, 32'h200);
        chk("sim memWe data", 32'(memWe), 32'd0);
        memAck = 1; memRData = 32'hA5A5A5A5;
        step();
        memAck = 0;
        chk("sim memReq gap", 32'(memReq), 32'd0);
        chk("sim stall_M", 32'(stall_M), 32'd0);
        chk("sim stall_F gap", 32'(stall_F), 32'd1);
        chk("sim readData_M", readData_M, 32'hA5A5A5A5);
        memRead_M = 0;
        step();
        chk("sim memReq fetch", 32'(memReq), 32'd1);
        chk("sim memAddr fetch", memAddr, 32'h8);
        chk("sim stall_F wait", 32'(stall_F), 32'd1);
        step();
        memAck = 1; memRData = 32'h00000013;
        step();
        memAck = 0;
        chk("sim stall_F done", 32'(stall_F), 32'd0);
        chk("sim instr_F", instr_F, 32'h00000013);
        fetchReq_F = 0;
        step();

        // Flush during a fetch: result dropped, new pc fetched
        fetchReq_F = 1; pc_F = 32'h20;
        step();
        chk("fl memAddr old", memAddr, 32'h20);
        flush_F = 1;
        step();
        flush_F = 0; pc_F = 32'h30;
        chk("fl memReq still", 32'(memReq), 32'd1);
        memAck = 1; memRData = 32'h00BADBAD;
        step();
        memAck = 0;
        chk("fl instr_F kept", instr_F, 32'h00000013);
        chk("fl stall_F", 32'(stall_F), 32'd1);
        step();
        chk("fl memAddr new", memAddr, 32'h30);
        memAck = 1; memRData = 32'h0000600D;
        step();
        memAck = 0;
        chk("fl stall_F done", 32'(stall_F), 32'd0);
        chk("fl instr_F new", instr_F, 32'h0000600D);
        fetchReq_F = 0;
        step();

        // Reset mid-access, then a late ack
        memRead_M = 1; addr_M = 32'h300;
        step();
        chk("rm memReq", 32'(memReq), 32'd1);
        reset = 1; memRead_M = 0;
        step();
        reset = 0;
        chk("rm memReq", 32'(memReq), 32'd0);
        chk("rm memAddr", memAddr, 32'h0);
        chk("rm readData_M", readData_M, 32'h0);
        chk("rm instr_F", instr_F, 32'h0);
        memAck = 1; memRData = 32'hFFFFFFFF;
        step();
        memAck = 0;
        chk("late memReq", 32'(memReq), 32'd0);
        chk("late readData_M", readData_M, 32'h0);
        chk("late instr_F", instr_F, 32'h0);
        chk("late stall_M", 32'(stall_M), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
